// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART byte receiver.
// Holds the receiver state encoding and the baud divisor calculation.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } rx_state_t;

    localparam logic UART_IDLE_LEVEL = 1'b1;

    function automatic int calcDivisor(input int clkHz, input int baud, input int os);
        return clkHz / (baud * os);
    endfunction

endpackage

// File: rtl/uart_byte_receiver_if.sv
// Serial line in, received-byte strobe bundle out.
// The receiver drives the master side; the downstream stage uses the slave side.
interface uart_byte_receiver_if #(
    parameter int WIDTH = 8
);
    logic             rx;
    logic [WIDTH-1:0] byteOut;
    logic             byteValid;
    logic             frameError;
    logic             busy;

    modport master (
        input  rx,
        output byteOut,
        output byteValid,
        output frameError,
        output busy
    );

    modport slave (
        output rx,
        input  byteOut,
        input  byteValid,
        input  frameError,
        input  busy
    );
endinterface

// File: rtl/baud_tick_gen.sv
// Oversample tick generator: one-clk tick every DIVISOR clks.
// Held at zero while clear is high so the first tick lands DIVISOR clks after release.
module baud_tick_gen #(
    parameter int DIVISOR = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);
    localparam int CW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIVISOR - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clear || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = !clear && (cnt == LAST);
endmodule

// File: rtl/uart_byte_receiver.sv
// 8N1 UART receiver: synchronizer, oversampled frame FSM and registered byte/error strobes.
// Good bytes pulse byteValid for one clk; a low stop bit pulses frameError instead.
module uart_byte_receiver
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int BAUD        = 9600,
    parameter int OVERSAMPLE  = 16,
    parameter int WIDTH       = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    uart_byte_receiver_if.master bus
);
    localparam int DIVISOR = calcDivisor(CLK_FREQ_HZ, BAUD, OVERSAMPLE);
    localparam int SCNT_W  = $clog2(OVERSAMPLE);
    localparam int BCNT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [SCNT_W-1:0] MID_START = SCNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SCNT_W-1:0] BIT_END   = SCNT_W'(OVERSAMPLE - 1);
    localparam logic [BCNT_W-1:0] BIT_LAST  = BCNT_W'(WIDTH - 1);

    if (DIVISOR < 2) begin : g_divisor_check
        $error("uart_byte_receiver: clock too slow for BAUD*OVERSAMPLE (DIVISOR < 2)");
    end
    if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0) begin : g_oversample_check
        $error("uart_byte_receiver: OVERSAMPLE must be even and at least 8");
    end

    rx_state_t         state, nextState;
    logic              rxMeta, rxS;
    logic [SCNT_W-1:0] sampleCnt;
    logic [BCNT_W-1:0] bitCnt;
    logic [WIDTH-1:0]  shiftReg;
    logic              tick, tickClear, sampleAt;

    assign tickClear = (state == IDLE);

    baud_tick_gen #(.DIVISOR(DIVISOR)) u_tick (
        .clk   (clk),
        .reset (reset),
        .clear (tickClear),
        .tick  (tick)
    );

    // Once past START the counter is restarted, so BIT_END falls on the middle of every later bit.
    assign sampleAt = tick && (sampleCnt == ((state == START) ? MID_START : BIT_END));
    assign bus.busy = (state != IDLE);

    always_comb begin
        nextState = state;
        unique case (state)
            IDLE:      if (!rxS) nextState = START;
            START:     if (sampleAt) nextState = rxS ? IDLE : DATA;
            DATA:      if (sampleAt && bitCnt == BIT_LAST) nextState = STOP;
            STOP:      if (sampleAt) nextState = rxS ? IDLE : WAIT_HIGH;
            WAIT_HIGH: if (rxS) nextState = IDLE;
            default:   nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rxMeta         <= UART_IDLE_LEVEL;
            rxS            <= UART_IDLE_LEVEL;
            state          <= IDLE;
            sampleCnt      <= '0;
            bitCnt         <= '0;
            shiftReg       <= '0;
            bus.byteOut    <= '0;
            bus.byteValid  <= 1'b0;
            bus.frameError <= 1'b0;
        end else begin
            rxMeta         <= bus.rx;
            rxS            <= rxMeta;
            state          <= nextState;
            bus.byteValid  <= 1'b0;
            bus.frameError <= 1'b0;

            if (state == IDLE) begin
                sampleCnt <= '0;
                bitCnt    <= '0;
            end else if (tick && state != WAIT_HIGH) begin
                sampleCnt <= sampleAt ? '0 : sampleCnt + SCNT_W'(1);
            end

            if (state == DATA && sampleAt) begin
                shiftReg <= {rxS, shiftReg[WIDTH-1:1]};
                bitCnt   <= (bitCnt == BIT_LAST) ? '0 : bitCnt + BCNT_W'(1);
            end

            // A low stop bit drops the frame; byteOut keeps the last good byte.
            if (state == STOP && sampleAt) begin
                if (rxS) begin
                    bus.byteOut   <= shiftReg;
                    bus.byteValid <= 1'b1;
                end else begin
                    bus.frameError <= 1'b1;
                end
            end
        end
    end
endmodule
